// File: rtl/uart_defines.sv
// uart_defines: shared constants and types for the UART receive path
// Holds the FIFO geometry, IIR codes, FCR trigger-level encodings and read-FSM states.
package uart_defines;
  localparam int FIFO_DEPTH = 16;
  localparam int CNT_W = 5;
  localparam int TOUT_W = 10;
  localparam logic [3:0] IIR_NONE = 4'b0001;
  localparam logic [3:0] IIR_RLS = 4'b0110;
  localparam logic [3:0] IIR_RDA = 4'b0100;
  localparam logic [3:0] IIR_CTI = 4'b1100;
  typedef enum logic [1:0] {TRIG_1 = 2'b00, TRIG_4 = 2'b01, TRIG_8 = 2'b10, TRIG_14 = 2'b11} trig_e;
  typedef enum logic [1:0] {IDLE, POP, SETTLE} rd_state_e;
endpackage

// File: rtl/uart_rx_tout.sv
// uart_rx_tout: character-timeout counter (four frame times) and timeout flag
// Ports: clk, wb_rst_i (async, active-high); bit_tick, rx_push, rf_pop, rbr_rd strobes;
//        char_bits (bit-times per frame); rf_count (FIFO occupancy); tout_flag (timeout pending).
module uart_rx_tout import uart_defines::*; #(
  parameter int CNT_W = uart_defines::CNT_W,
  parameter int TOUT_W = uart_defines::TOUT_W
) (
  input  logic             clk,
  input  logic             wb_rst_i,
  input  logic             bit_tick,
  input  logic             rx_push,
  input  logic             rf_pop,
  input  logic             rbr_rd,
  input  logic [3:0]       char_bits,
  input  logic [CNT_W-1:0] rf_count,
  output logic             tout_flag
);
  logic [TOUT_W-1:0] tout_cnt;
  logic reload, expire;
  // The flag fires only on the tick that moves the counter from 1 to 0, so a
  // counter parked at 0 (after reset, or after expiry) never re-arms it.
  always_comb begin
    reload = rx_push | rf_pop | (rf_count == '0);
    expire = ~reload & bit_tick & (tout_cnt == TOUT_W'(1));
  end
  always_ff @(posedge clk or posedge wb_rst_i)
    if (wb_rst_i) begin
      tout_cnt <= '0;
      tout_flag <= 1'b0;
    end else begin
      tout_cnt <= reload ? TOUT_W'({char_bits, 2'b00}) :
                  (bit_tick && tout_cnt != '0) ? tout_cnt - TOUT_W'(1) : tout_cnt;
      tout_flag <= (rbr_rd | rx_push) ? 1'b0 : expire ? 1'b1 : tout_flag;
    end
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: RX FIFO read sequencer, line-status latch and RX interrupt arbiter
// Ports: clk, wb_rst_i (async, active-high); fifo_en, trig_lvl, ier, char_bits configuration;
//        bit_tick, rx_push, rf_count, rf_error_bit, rf_overrun from the receiver/FIFO;
//        rbr_rd, lsr_rd host strobes; rf_pop, reset_status to the FIFO;
//        lsr_dr, lsr_err, iir, int_o to the register file.
// Optional: define UART_RX_CTRL_DMA_EN to add the active-low rxrdy_n DMA request output.
module uart_rx_ctrl import uart_defines::*; #(
  parameter int FIFO_DEPTH = uart_defines::FIFO_DEPTH,
  parameter int CNT_W = uart_defines::CNT_W,
  parameter int TOUT_W = uart_defines::TOUT_W
) (
  input  logic             clk,
  input  logic             wb_rst_i,
  input  logic             fifo_en,
  input  logic [1:0]       trig_lvl,
  input  logic [2:0]       ier,
  input  logic [3:0]       char_bits,
  input  logic             bit_tick,
  input  logic             rx_push,
  input  logic [CNT_W-1:0] rf_count,
  input  logic             rf_error_bit,
  input  logic             rf_overrun,
  input  logic             rbr_rd,
  input  logic             lsr_rd,
  output logic             rf_pop,
  output logic             reset_status,
  output logic             lsr_dr,
  output logic             lsr_err,
  output logic [3:0]       iir,
  output logic             int_o
`ifdef UART_RX_CTRL_DMA_EN
  ,
  output logic             rxrdy_n
`endif
);
  rd_state_e state;
  logic err_q, ovr_q, lsr_set, rda, tout_flag;
  logic [CNT_W-1:0] thr;
  logic [3:0] iir_nxt;
  // The top trigger level sits two entries below full, as on a 16550.
  always_comb begin
    thr = !fifo_en ? CNT_W'(1) :
          trig_lvl == TRIG_1 ? CNT_W'(1) :
          trig_lvl == TRIG_4 ? CNT_W'(4) :
          trig_lvl == TRIG_8 ? CNT_W'(8) : CNT_W'(FIFO_DEPTH - 2);
    rda = rf_count >= thr;
    lsr_set = (rf_error_bit & ~err_q) | (rf_overrun & ~ovr_q);
    iir_nxt = (lsr_err & ier[1]) ? IIR_RLS :
              (rda & ier[0]) ? IIR_RDA :
              (tout_flag & ier[2] & fifo_en) ? IIR_CTI : IIR_NONE;
  end
  uart_rx_tout #(.CNT_W(CNT_W), .TOUT_W(TOUT_W)) u_tout (
    .clk(clk), .wb_rst_i(wb_rst_i), .bit_tick(bit_tick), .rx_push(rx_push),
    .rf_pop(rf_pop), .rbr_rd(rbr_rd), .char_bits(char_bits), .rf_count(rf_count),
    .tout_flag(tout_flag)
  );
  // SETTLE gives the FIFO one cycle to update rf_count before another read can pop.
  always_ff @(posedge clk or posedge wb_rst_i)
    if (wb_rst_i) begin
      state <= IDLE;
      rf_pop <= 1'b0;
      reset_status <= 1'b0;
      lsr_dr <= 1'b0;
      lsr_err <= 1'b0;
      err_q <= 1'b0;
      ovr_q <= 1'b0;
      iir <= IIR_NONE;
      int_o <= 1'b0;
    end else begin
      state <= state == IDLE ? ((rbr_rd && rf_count != '0) ? POP : IDLE) :
               state == POP ? SETTLE : IDLE;
      rf_pop <= state == IDLE && rbr_rd && rf_count != '0;
      reset_status <= lsr_rd;
      lsr_dr <= rf_count != '0;
      lsr_err <= lsr_set | (lsr_err & ~lsr_rd);
      err_q <= rf_error_bit;
      ovr_q <= rf_overrun;
      iir <= iir_nxt;
      int_o <= ~iir_nxt[0];
    end
`ifdef UART_RX_CTRL_DMA_EN
  always_ff @(posedge clk or posedge wb_rst_i)
    if (wb_rst_i) rxrdy_n <= 1'b1;
    else rxrdy_n <= (rda | tout_flag) ? 1'b0 : (rf_count == '0) ? 1'b1 : rxrdy_n;
`endif
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed self-checking bench for uart_rx_ctrl against a behavioural model
module tb_uart_rx_ctrl;
  logic clk = 1'b0;
  logic wb_rst_i = 1'b1;
  logic fifo_en = 1'b0;
  logic [1:0] trig_lvl = 2'd0;
  logic [2:0] ier = 3'd0;
  logic [3:0] char_bits = 4'd10;
  logic bit_tick = 1'b0, rx_push = 1'b0, rf_error_bit = 1'b0, rf_overrun = 1'b0;
  logic rbr_rd = 1'b0, lsr_rd = 1'b0;
  logic [4:0] rf_count = 5'd0;
  logic rf_pop, reset_status, lsr_dr, lsr_err, int_o;
  logic [3:0] iir;
`ifdef UART_RX_CTRL_DMA_EN
  logic rxrdy_n;
`endif
  int checks = 0, failures = 0, pops = 0;
  int cnt = 0, busy = 0, t = 1023;
  bit m_pop, m_rs, m_dr, m_err, m_flag, perr, povr;
  logic [3:0] m_iir = 4'b0001;

  always #5 clk = ~clk;

  uart_rx_ctrl dut (
    .clk(clk), .wb_rst_i(wb_rst_i), .fifo_en(fifo_en), .trig_lvl(trig_lvl), .ier(ier),
    .char_bits(char_bits), .bit_tick(bit_tick), .rx_push(rx_push), .rf_count(rf_count),
    .rf_error_bit(rf_error_bit), .rf_overrun(rf_overrun), .rbr_rd(rbr_rd), .lsr_rd(lsr_rd),
    .rf_pop(rf_pop), .reset_status(reset_status), .lsr_dr(lsr_dr), .lsr_err(lsr_err),
    .iir(iir), .int_o(int_o)
`ifdef UART_RX_CTRL_DMA_EN
    , .rxrdy_n(rxrdy_n)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    busy = 0; t = 1023; m_pop = 0; m_rs = 0; m_dr = 0; m_err = 0; m_flag = 0;
    perr = 0; povr = 0; m_iir = 4'b0001;
  endtask

  // Advances the model by the clock edge just passed, using the inputs held across it.
  // t counts bit ticks since the last reload; 1023 marks "expired, idle" after reset.
  task automatic model_step();
    int lim, thr;
    bit rda, reload, accept;
    lim = 4 * int'(char_bits);
    thr = !fifo_en ? 1 : trig_lvl == 0 ? 1 : trig_lvl == 1 ? 4 : trig_lvl == 2 ? 8 : 14;
    rda = cnt >= thr;
    m_iir = (m_err && ier[1]) ? 4'b0110 : (rda && ier[0]) ? 4'b0100 :
            (m_flag && ier[2] && fifo_en) ? 4'b1100 : 4'b0001;
    reload = rx_push || m_pop || cnt == 0;
    if (rbr_rd || rx_push) m_flag = 0;
    else if (!reload && bit_tick && t == lim - 1) m_flag = 1;
    t = reload ? 0 : (bit_tick && t < lim) ? t + 1 : t;
    m_err = ((rf_error_bit && !perr) || (rf_overrun && !povr)) || (m_err && !lsr_rd);
    perr = rf_error_bit;
    povr = rf_overrun;
    m_rs = lsr_rd;
    m_dr = cnt != 0;
    accept = rbr_rd && cnt > 0 && busy == 0;
    cnt = cnt + int'(rx_push) - int'(m_pop);
    busy = accept ? 2 : busy > 0 ? busy - 1 : 0;
    m_pop = accept;
    rf_count = 5'(cnt);
  endtask

  task automatic compare();
    chk("rf_pop", rf_pop, m_pop);
    chk("reset_status", reset_status, m_rs);
    chk("lsr_dr", lsr_dr, m_dr);
    chk("lsr_err", lsr_err, m_err);
    chk("iir", iir, m_iir);
    chk("int_o", int_o, m_iir != 4'b0001);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    model_step();
    compare();
    rx_push = 0; rbr_rd = 0; lsr_rd = 0; bit_tick = 0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    compare();
    chk("rst_iir", iir, 4'b0001);
    chk("rst_int", int_o, 1'b0);
    wb_rst_i = 0;
    fifo_en = 1; trig_lvl = 2'b01; ier = 3'b001;
    cyc();
    repeat (4) begin rx_push = 1; cyc(); end
    chk("rda_below_trig", iir, 4'b0001);
    cyc();
    chk("rda_iir", iir, 4'b0100);
    chk("rda_int", int_o, 1'b1);
    rbr_rd = 1; cyc();
    chk("pop_pulse", rf_pop, 1'b1);
    cyc();
    chk("pop_single", rf_pop, 1'b0);
    cyc();
    chk("iir_after_pop", iir, 4'b0001);
    rbr_rd = 1; cyc(); cyc(); cyc();
    pops = 0;
    repeat (3) begin rbr_rd = 1; cyc(); pops += int'(rf_pop); end
    repeat (3) begin cyc(); pops += int'(rf_pop); end
    chk("held_rbr_pops", pops, 1);
    ier = 3'b100;
    repeat (39) begin bit_tick = 1; cyc(); end
    cyc();
    chk("cti_not_yet", iir, 4'b0001);
    bit_tick = 1; cyc();
    cyc();
    chk("cti_iir", iir, 4'b1100);
    rbr_rd = 1; cyc();
    cyc();
    chk("cti_cleared", iir, 4'b0001);
    ier = 3'b011; trig_lvl = 2'b00;
    rx_push = 1; cyc();
    cyc();
    chk("rda_pending", iir, 4'b0100);
    rf_error_bit = 1; cyc();
    chk("err_set", lsr_err, 1'b1);
    cyc();
    chk("rls_iir", iir, 4'b0110);
    lsr_rd = 1; cyc();
    chk("rs_pulse", reset_status, 1'b1);
    chk("err_clr", lsr_err, 1'b0);
    cyc();
    chk("rls_to_rda", iir, 4'b0100);
    rf_error_bit = 0; cyc();
    rf_overrun = 1; lsr_rd = 1; cyc();
    chk("set_wins", lsr_err, 1'b1);
    lsr_rd = 1; cyc();
    chk("ovr_clr", lsr_err, 1'b0);
    rf_overrun = 0; cyc();
    rx_push = 1; cyc();
    rbr_rd = 1; cyc();
    chk("pop_before_rst", rf_pop, 1'b1);
    #2 wb_rst_i = 1;
    #1;
    chk("async_rst_pop", rf_pop, 1'b0);
    chk("async_rst_iir", iir, 4'b0001);
    chk("async_rst_int", int_o, 1'b0);
    model_reset();
    @(negedge clk);
    compare();
    wb_rst_i = 0;
    cyc();
    rbr_rd = 1; cyc();
    chk("pop_after_rst", rf_pop, 1'b1);
    cyc(); cyc();
    fifo_en = 0; ier = 3'b100; trig_lvl = 2'b11;
    repeat (40) begin bit_tick = 1; cyc(); end
    cyc();
    chk("cti_fifo_off", iir, 4'b0001);
    ier = 3'b001; cyc();
    chk("rda_fifo_off", iir, 4'b0100);
    fifo_en = 1;
    repeat (12) begin rx_push = 1; cyc(); end
    cyc();
    chk("thr14_below", iir, 4'b0001);
    rx_push = 1; cyc();
    cyc();
    chk("thr14_hit", iir, 4'b0100);
    repeat (3) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
